// File: rtl/conv_pkg.sv
// conv_pkg: shared types and limits for the 5x5 convolution control path.
//   IMAGE_MAX_W/H : largest accepted frame dimensions
//   CW/RW         : column/row index widths
//   col_t/row_t   : pixel coordinate types
//   cntrl_state_t : frame sequencer state
//   kernel_pos_t  : per-centre border flags, 1 = that neighbour lies outside the image
package conv_pkg;
   localparam int IMAGE_MAX_W = 4096;
   localparam int IMAGE_MAX_H = 4096;
   localparam int CW          = $clog2(IMAGE_MAX_W);
   localparam int RW          = $clog2(IMAGE_MAX_H);

   typedef logic [CW-1:0] col_t;
   typedef logic [RW-1:0] row_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } cntrl_state_t;

   // Bit order, MSB first: w2 w1 e1 e2 n2 n1 s1 s2
   typedef struct packed {
      logic w2;
      logic w1;
      logic e1;
      logic e2;
      logic n2;
      logic n1;
      logic s1;
      logic s2;
   } kernel_pos_t;
endpackage

// File: rtl/conv_raster_cnt.sv
// conv_raster_cnt: raster-order (x,y) counter bounded by a runtime W x H.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous return to (0,0)
//   en       : advance one position; x wraps at W-1 and bumps y, y wraps at H-1
//   w, h     : frame dimensions (>= 1)
//   x, y     : current position
//   last     : current position is (W-1,H-1)
module conv_raster_cnt #(
   parameter int CW = 12,
   parameter int RW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [CW:0]   w,
   input  logic [RW:0]   h,
   output logic [CW-1:0] x,
   output logic [RW-1:0] y,
   output logic          last
);
   localparam logic [CW:0] ONE_W = (CW+1)'(1);
   localparam logic [RW:0] ONE_H = (RW+1)'(1);

   logic x_end, y_end;

   assign x_end = ({1'b0, x} == (w - ONE_W));
   assign y_end = ({1'b0, y} == (h - ONE_H));
   assign last  = x_end & y_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (x_end) begin
            x <= '0;
            y <= y_end ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end
endmodule

// File: rtl/conv_cntrl.sv
// conv_cntrl: frame sequencer for the 5x5 convolution datapath.
//   Accepts a raster pixel stream, drives line-buffer pushes, appends 2W+2 padding
//   pushes so the window drains, and emits one token per centre pixel with its
//   coordinates and border flags.
// Ports:
//   clk, rst              clock, async active-high reset
//   cfg_start_i/w_i/h_i   frame start and dimensions (sampled in IDLE only)
//   cfg_err_o             1-cycle pulse: start rejected for bad W/H
//   busy_o, done_o        frame in progress / final output handshake
//   in_vld_i, in_rdy_o    input pixel handshake
//   lb_push_o/pad_o/col_o line-buffer shift, padding flag, column address
//   out_vld_o, out_rdy_i  output token handshake (single register stage)
//   out_x_o/y_o/pos_o/eof_o  centre coordinates, border flags, last-centre flag
module conv_cntrl
   import conv_pkg::*;
#(
   parameter int IMAGE_MAX_W = conv_pkg::IMAGE_MAX_W,
   parameter int IMAGE_MAX_H = conv_pkg::IMAGE_MAX_H,
   parameter int CW          = $clog2(IMAGE_MAX_W),
   parameter int RW          = $clog2(IMAGE_MAX_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_start_i,
   input  logic [CW:0]   cfg_w_i,
   input  logic [RW:0]   cfg_h_i,
   output logic          cfg_err_o,
   output logic          busy_o,
   output logic          done_o,
   input  logic          in_vld_i,
   output logic          in_rdy_o,
   output logic          lb_push_o,
   output logic          lb_pad_o,
   output logic [CW-1:0] lb_col_o,
   output logic          out_vld_o,
   input  logic          out_rdy_i,
   output logic [CW-1:0] out_x_o,
   output logic [RW-1:0] out_y_o,
   output logic [7:0]    out_pos_o,
   output logic          out_eof_o
);
   localparam logic [CW:0]   MIN_W = (CW+1)'(3);
   localparam logic [RW:0]   MIN_H = (RW+1)'(3);
   localparam logic [CW:0]   MAX_W = (CW+1)'(IMAGE_MAX_W);
   localparam logic [RW:0]   MAX_H = (RW+1)'(IMAGE_MAX_H);
   localparam logic [CW:0]   W1    = (CW+1)'(1);
   localparam logic [CW:0]   W2    = (CW+1)'(2);
   localparam logic [CW:0]   W3    = (CW+1)'(3);
   localparam logic [RW:0]   H1    = (RW+1)'(1);
   localparam logic [RW:0]   H2    = (RW+1)'(2);
   localparam logic [RW:0]   H3    = (RW+1)'(3);
   localparam logic [CW-1:0] COL2  = CW'(2);
   localparam logic [RW-1:0] ROW2  = RW'(2);

   cntrl_state_t state_q, state_d;
   logic [CW:0]  w_q;
   logic [RW:0]  h_q;

   logic          adv, push, load, start_ok, cfg_ok, cfg_err_d;
   logic [CW-1:0] ix, cx;
   logic [RW-1:0] iy, cy;
   logic          in_last, c_last, in_cnt_en;
   kernel_pos_t   pos_c, pos_q;

   // A new token may be loaded whenever the output register is empty or draining.
   assign adv    = !out_vld_o | out_rdy_i;
   assign cfg_ok = (cfg_w_i >= MIN_W) && (cfg_w_i <= MAX_W) &&
                   (cfg_h_i >= MIN_H) && (cfg_h_i <= MAX_H);
   assign busy_o = (state_q != IDLE);

   // Padding pushes do not advance the input counter; their column is don't-care.
   assign in_cnt_en = push & ((state_q == FILL) | (state_q == RUN));
   assign lb_col_o  = ((state_q == FILL) || (state_q == RUN)) ? ix : '0;
   assign lb_push_o = push;

   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      load      = 1'b0;
      start_ok  = 1'b0;
      cfg_err_d = 1'b0;
      in_rdy_o  = 1'b0;
      lb_pad_o  = 1'b0;
      done_o    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg_start_i) begin
               if (cfg_ok) begin
                  start_ok = 1'b1;
                  state_d  = FILL;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         FILL: begin
            in_rdy_o = adv;
            push     = in_vld_i & adv;
            // Pixel (2,2) completes the first full window; on a 3x3 frame it is
            // also the last input pixel, so go straight to padding.
            if (push && (ix == COL2) && (iy == ROW2)) begin
               load    = 1'b1;
               state_d = in_last ? FLUSH : RUN;
            end
         end
         RUN: begin
            in_rdy_o = adv;
            push     = in_vld_i & adv;
            load     = push;
            if (push && in_last) state_d = FLUSH;
         end
         FLUSH: begin
            // Stop padding once the final centre sits in the output register.
            push     = adv & !(out_vld_o & out_eof_o);
            load     = push;
            lb_pad_o = push;
            done_o   = out_vld_o & out_eof_o & out_rdy_i;
            if (done_o) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         w_q       <= '0;
         h_q       <= '0;
         cfg_err_o <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_err_o <= cfg_err_d;
         if (start_ok) begin
            w_q <= cfg_w_i;
            h_q <= cfg_h_i;
         end
      end
   end

   conv_raster_cnt #(.CW(CW), .RW(RW)) u_in_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_ok),
      .en   (in_cnt_en),
      .w    (w_q),
      .h    (h_q),
      .x    (ix),
      .y    (iy),
      .last (in_last)
   );

   conv_raster_cnt #(.CW(CW), .RW(RW)) u_ctr_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_ok),
      .en   (load),
      .w    (w_q),
      .h    (h_q),
      .x    (cx),
      .y    (cy),
      .last (c_last)
   );

   // Border flags for the current centre, in W/H-width unsigned arithmetic.
   always_comb begin
      logic [CW:0] cxe;
      logic [RW:0] cye;
      cxe      = {1'b0, cx};
      cye      = {1'b0, cy};
      pos_c.w2 = cxe < W2;
      pos_c.w1 = cxe < W1;
      pos_c.e1 = cxe > (w_q - W2);
      pos_c.e2 = cxe > (w_q - W3);
      pos_c.n2 = cye < H2;
      pos_c.n1 = cye < H1;
      pos_c.s1 = cye > (h_q - H2);
      pos_c.s2 = cye > (h_q - H3);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_o <= 1'b0;
         out_x_o   <= '0;
         out_y_o   <= '0;
         pos_q     <= '0;
         out_eof_o <= 1'b0;
      end else if (load) begin
         out_vld_o <= 1'b1;
         out_x_o   <= cx;
         out_y_o   <= cy;
         pos_q     <= pos_c;
         out_eof_o <= c_last;
      end else if (out_rdy_i) begin
         out_vld_o <= 1'b0;
      end
   end

   assign out_pos_o = pos_q;
endmodule

// File: tb/tb_conv_cntrl.sv
// tb_conv_cntrl: directed bench for the convolution frame sequencer.
module tb_conv_cntrl;
   localparam int CW = 12;
   localparam int RW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_start;
   logic [CW:0]   cfg_w;
   logic [RW:0]   cfg_h;
   logic          cfg_err, busy, done;
   logic          in_vld, in_rdy;
   logic          lb_push, lb_pad;
   logic [CW-1:0] lb_col;
   logic          out_vld, out_rdy;
   logic [CW-1:0] out_x;
   logic [RW-1:0] out_y;
   logic [7:0]    out_pos;
   logic          out_eof;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int         x;
      int         y;
      logic [7:0] pos;
      logic       eof;
   } tok_t;

   tok_t toks[$];
   tok_t ref_toks[$];
   int   n_push, n_pad, n_in, n_done, n_err, first_vld_push, col_bad, col_max;
   bit   timed_out;

   always #5 clk = ~clk;

   conv_cntrl dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_start_i(cfg_start),
      .cfg_w_i    (cfg_w),
      .cfg_h_i    (cfg_h),
      .cfg_err_o  (cfg_err),
      .busy_o     (busy),
      .done_o     (done),
      .in_vld_i   (in_vld),
      .in_rdy_o   (in_rdy),
      .lb_push_o  (lb_push),
      .lb_pad_o   (lb_pad),
      .lb_col_o   (lb_col),
      .out_vld_o  (out_vld),
      .out_rdy_i  (out_rdy),
      .out_x_o    (out_x),
      .out_y_o    (out_y),
      .out_pos_o  (out_pos),
      .out_eof_o  (out_eof)
   );

   // Reference border flags, order w2 w1 e1 e2 n2 n1 s1 s2.
   function automatic logic [7:0] exp_pos(int x, int y, int w, int h);
      return {x < 2, x < 1, x > w - 2, x > w - 3, y < 2, y < 1, y > h - 2, y > h - 3};
   endfunction

   // Index of the first token that departs from raster order / expected flags, -1 if none.
   function automatic int stream_bad(int w, int h);
      for (int i = 0; i < toks.size(); i++) begin
         if (i >= w * h) return i;
         if (toks[i].x != i % w || toks[i].y != i / w ||
             toks[i].pos !== exp_pos(i % w, i / w, w, h) ||
             toks[i].eof !== (i == w * h - 1)) return i;
      end
      return -1;
   endfunction

   // Runs one frame and records what the DUT did; callers do the comparing.
   // rdy_mode 1 toggles out_rdy, gap 1 inserts random input bubbles,
   // poke >= 0 fires extra cfg_start pulses during the frame.
   task automatic drive_frame(input int w, input int h, input int rdy_mode,
                              input int gap, input int poke, input int budget);
      int   cyc, exp_col, gap_left;
      tok_t t;
      toks.delete();
      n_push = 0; n_pad = 0; n_in = 0; n_done = 0; n_err = 0;
      first_vld_push = -1; col_bad = 0; col_max = 0; timed_out = 1'b0;
      exp_col = 0; gap_left = 0;
      @(negedge clk);
      cfg_w = (CW+1)'(w); cfg_h = (RW+1)'(h); cfg_start = 1'b1;
      in_vld = 1'b0; out_rdy = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      cyc = 0;
      forever begin
         if (cyc >= budget) begin
            timed_out = 1'b1;
            break;
         end
         if (gap != 0) begin
            if (gap_left > 0) begin
               in_vld = 1'b0;
               gap_left--;
            end else begin
               in_vld = 1'b1;
               if ($urandom_range(0, 2) == 0) gap_left = $urandom_range(1, 6);
            end
         end else begin
            in_vld = 1'b1;
         end
         out_rdy   = (rdy_mode != 0) ? (cyc % 2 == 0) : 1'b1;
         cfg_start = 1'b0;
         if (poke >= 0 && cyc == poke) begin
            cfg_w = 13'd3; cfg_h = 13'd3; cfg_start = 1'b1;
         end
         if (poke >= 0 && cyc == poke + 2) begin
            cfg_w = 13'd2; cfg_h = 13'd3; cfg_start = 1'b1;
         end
         #1;
         if (!busy) break;
         if (out_vld && first_vld_push < 0) first_vld_push = n_push - 1;
         if (lb_push) begin
            n_push++;
            if (lb_pad) n_pad++;
            else begin
               if (int'(lb_col) != exp_col) col_bad++;
               if (int'(lb_col) > col_max) col_max = int'(lb_col);
               exp_col = (exp_col + 1) % w;
            end
         end
         if (in_vld && in_rdy) n_in++;
         if (out_vld && out_rdy) begin
            t.x = int'(out_x); t.y = int'(out_y); t.pos = out_pos; t.eof = out_eof;
            toks.push_back(t);
         end
         if (done) n_done++;
         if (cfg_err) n_err++;
         @(negedge clk);
         cyc++;
      end
      in_vld = 1'b0; cfg_start = 1'b0; out_rdy = 1'b1;
      cfg_w = '0; cfg_h = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_start = 1'b0; cfg_w = '0; cfg_h = '0; in_vld = 1'b0; out_rdy = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if ({busy, in_rdy, lb_push, lb_pad, out_vld, out_eof, done, cfg_err} !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b want 00000000",
                  {busy, in_rdy, lb_push, lb_pad, out_vld, out_eof, done, cfg_err});
      end
      vectors++;
      if ({lb_col, out_x, out_y, out_pos} !== 44'd0) begin
         miscompares++;
         $display("FAIL reset_data: got %h want 0", {lb_col, out_x, out_y, out_pos});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_3x3();
      drive_frame(3, 3, 0, 0, -1, 200);
      vectors++;
      if (timed_out !== 1'b0) begin miscompares++; $display("FAIL 3x3_timeout: frame did not end"); end
      vectors++;
      if (n_in != 9) begin miscompares++; $display("FAIL 3x3_inputs: got %0d want 9", n_in); end
      vectors++;
      if (n_pad != 8) begin miscompares++; $display("FAIL 3x3_pads: got %0d want 8", n_pad); end
      vectors++;
      if (n_push != 17) begin miscompares++; $display("FAIL 3x3_pushes: got %0d want 17", n_push); end
      vectors++;
      if (first_vld_push != 8) begin
         miscompares++; $display("FAIL 3x3_first_out: got push %0d want 8", first_vld_push);
      end
      vectors++;
      if (toks.size() != 9) begin miscompares++; $display("FAIL 3x3_count: got %0d want 9", toks.size()); end
      vectors++;
      if (stream_bad(3, 3) != -1) begin
         miscompares++; $display("FAIL 3x3_stream: first bad token %0d want -1", stream_bad(3, 3));
      end
      if (toks.size() == 9) begin
         vectors++;
         if (toks[0].pos !== 8'b1100_1100) begin
            miscompares++; $display("FAIL 3x3_pos00: got %b want 11001100", toks[0].pos);
         end
         vectors++;
         if (toks[8].pos !== 8'b0011_0011) begin
            miscompares++; $display("FAIL 3x3_pos22: got %b want 00110011", toks[8].pos);
         end
      end
      vectors++;
      if (n_done != 1) begin miscompares++; $display("FAIL 3x3_done: got %0d want 1", n_done); end
   endtask

   task automatic test_8x5_stall();
      drive_frame(8, 5, 1, 0, -1, 2000);
      vectors++;
      if (timed_out !== 1'b0) begin miscompares++; $display("FAIL 8x5_timeout: frame did not end"); end
      vectors++;
      if (toks.size() != 40) begin miscompares++; $display("FAIL 8x5_count: got %0d want 40", toks.size()); end
      vectors++;
      if (stream_bad(8, 5) != -1) begin
         miscompares++; $display("FAIL 8x5_stream: first bad token %0d want -1", stream_bad(8, 5));
      end
      vectors++;
      if (n_pad != 18) begin miscompares++; $display("FAIL 8x5_pads: got %0d want 18", n_pad); end
      vectors++;
      if (n_push != 58) begin miscompares++; $display("FAIL 8x5_pushes: got %0d want 58", n_push); end
      vectors++;
      if (n_done != 1) begin miscompares++; $display("FAIL 8x5_done: got %0d want 1", n_done); end
   endtask

   task automatic test_cfg_err();
      int bw[4] = '{2, 16, 4097, 16};
      int bh[4] = '{16, 4097, 3, 2};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cfg_w = (CW+1)'(bw[i]); cfg_h = (RW+1)'(bh[i]); cfg_start = 1'b1;
         @(negedge clk);
         cfg_start = 1'b0;
         #1;
         vectors++;
         if ({cfg_err, busy} !== 2'b10) begin
            miscompares++; $display("FAIL cfg_err_pulse[%0d]: got err,busy=%b want 10", i, {cfg_err, busy});
         end
         @(negedge clk);
         #1;
         vectors++;
         if ({cfg_err, busy} !== 2'b00) begin
            miscompares++; $display("FAIL cfg_err_clear[%0d]: got err,busy=%b want 00", i, {cfg_err, busy});
         end
      end
      drive_frame(16, 16, 0, 0, -1, 2000);
      vectors++;
      if (toks.size() != 256) begin miscompares++; $display("FAIL 16x16_count: got %0d want 256", toks.size()); end
      vectors++;
      if (stream_bad(16, 16) != -1) begin
         miscompares++; $display("FAIL 16x16_stream: first bad token %0d want -1", stream_bad(16, 16));
      end
      vectors++;
      if (n_err != 0 || n_done != 1) begin
         miscompares++; $display("FAIL 16x16_err_done: got err=%0d done=%0d want 0 1", n_err, n_done);
      end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      cfg_w = 13'd64; cfg_h = 13'd64; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0; in_vld = 1'b1; out_rdy = 1'b1;
      repeat (300) @(negedge clk);
      #1;
      vectors++;
      if ({busy, out_vld} !== 2'b11) begin
         miscompares++; $display("FAIL mid_run_active: got busy,vld=%b want 11", {busy, out_vld});
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if ({busy, in_rdy, lb_push, lb_pad, out_vld, out_eof, done, cfg_err} !== 8'd0 ||
          {lb_col, out_x, out_y, out_pos} !== 44'd0) begin
         miscompares++;
         $display("FAIL mid_run_reset: got ctrl=%b data=%h want 0",
                  {busy, in_rdy, lb_push, lb_pad, out_vld, out_eof, done, cfg_err},
                  {lb_col, out_x, out_y, out_pos});
      end
      @(negedge clk);
      rst = 1'b0; in_vld = 1'b0;
      drive_frame(64, 64, 0, 0, -1, 10000);
      vectors++;
      if (toks.size() != 4096) begin miscompares++; $display("FAIL 64x64_count: got %0d want 4096", toks.size()); end
      vectors++;
      if (stream_bad(64, 64) != -1) begin
         miscompares++; $display("FAIL 64x64_stream: first bad token %0d want -1", stream_bad(64, 64));
      end
      vectors++;
      if (n_push != 4226 || n_done != 1) begin
         miscompares++; $display("FAIL 64x64_push_done: got %0d/%0d want 4226/1", n_push, n_done);
      end
   endtask

   task automatic test_max_width();
      drive_frame(4096, 3, 0, 0, -1, 40000);
      vectors++;
      if (timed_out !== 1'b0) begin miscompares++; $display("FAIL maxw_timeout: frame did not end"); end
      vectors++;
      if (first_vld_push != 8194) begin
         miscompares++; $display("FAIL maxw_first_out: got push %0d want 8194", first_vld_push);
      end
      vectors++;
      if (col_max != 4095 || col_bad != 0) begin
         miscompares++; $display("FAIL maxw_cols: got max=%0d bad=%0d want 4095 0", col_max, col_bad);
      end
      vectors++;
      if (n_in != 12288 || toks.size() != 12288) begin
         miscompares++; $display("FAIL maxw_count: got in=%0d out=%0d want 12288", n_in, toks.size());
      end
      vectors++;
      if (stream_bad(4096, 3) != -1) begin
         miscompares++; $display("FAIL maxw_stream: first bad token %0d want -1", stream_bad(4096, 3));
      end
      if (toks.size() == 12288) begin
         vectors++;
         if (toks[4096 + 4093].pos[5:4] !== 2'b00) begin
            miscompares++; $display("FAIL maxw_e_4093: got %b want 00", toks[4096 + 4093].pos[5:4]);
         end
         vectors++;
         if (toks[4096 + 4094].pos[5:4] !== 2'b01) begin
            miscompares++; $display("FAIL maxw_e_4094: got %b want 01", toks[4096 + 4094].pos[5:4]);
         end
         vectors++;
         if (toks[4096 + 4095].pos[5:4] !== 2'b11) begin
            miscompares++; $display("FAIL maxw_e_4095: got %b want 11", toks[4096 + 4095].pos[5:4]);
         end
      end
   endtask

   task automatic test_gaps();
      int diff;
      drive_frame(8, 5, 0, 0, -1, 2000);
      ref_toks = toks;
      drive_frame(8, 5, 1, 1, 3, 5000);
      vectors++;
      if (n_err != 0) begin miscompares++; $display("FAIL gaps_start_ignored: got err=%0d want 0", n_err); end
      vectors++;
      if (toks.size() != ref_toks.size() || toks.size() != 40) begin
         miscompares++; $display("FAIL gaps_count: got %0d ref %0d want 40", toks.size(), ref_toks.size());
      end
      diff = -1;
      for (int i = 0; i < toks.size() && i < ref_toks.size(); i++) begin
         if (diff < 0 && (toks[i].x != ref_toks[i].x || toks[i].y != ref_toks[i].y ||
             toks[i].pos !== ref_toks[i].pos || toks[i].eof !== ref_toks[i].eof)) diff = i;
      end
      vectors++;
      if (diff != -1) begin miscompares++; $display("FAIL gaps_vs_ref: first differing token %0d want -1", diff); end
      vectors++;
      if (stream_bad(8, 5) != -1) begin
         miscompares++; $display("FAIL gaps_stream: first bad token %0d want -1", stream_bad(8, 5));
      end
      vectors++;
      if (n_pad != 18 || n_done != 1) begin
         miscompares++; $display("FAIL gaps_pad_done: got %0d/%0d want 18/1", n_pad, n_done);
      end
   endtask

   initial begin
      test_reset();
      test_3x3();
      test_8x5_stall();
      test_cfg_err();
      test_reset_mid_run();
      test_max_width();
      test_gaps();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
